// File: rtl/fp_std_sched_pkg.sv
// Shared definitions for the fp_std (24-bit, 1s/8e/15m) datapath and its schedulers.
package fp_pkg;

    localparam int FP_WIDTH = 24;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 15;

    // Bit of the 4-bit op field that flips the sign of operand B before any op.
    localparam int FP_NEG_B = 2;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_MAX  = 2'b01,
        FP_MIN  = 2'b10,
        FP_ZERO = 2'b11
    } fp_op_e;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp_t;

    // All-ones exponent marks inf/NaN; such operands pass straight through the adder.
    function automatic logic fp_is_special(input logic [FP_EXP_W-1:0] e);
        return &e;
    endfunction

endpackage

// File: rtl/fp_std.sv
// Combinational fp_std add/sub/max/min. Subnormals flush to zero, results truncate.
module fp_std
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result
);

    localparam int EW = FP_EXP_W;
    localparam int MW = FP_MAN_W;
    // hidden bit + mantissa + 3 guard bits for the aligned smaller operand
    localparam int SW = MW + 4;
    localparam logic [EW-1:0] EMAX = '1;

    fp_t fa, fb;
    fp_t big, sml, sum_res, res;
    logic a_ge, a_gt;
    logic [EW-1:0] diff;
    logic [SW-1:0] sig_b, sig_s, sig_sh, norm;
    logic [SW:0]   sum;
    logic [EW:0]   lz, exp_w;
    logic          unused_op3;

    // op[3] is reserved; kept only so the field stays 4 bits wide everywhere.
    assign unused_op3 = op[3];
    assign fa = a;
    assign fb = {b[WIDTH-1] ^ op[FP_NEG_B], b[WIDTH-2:0]};

    // Magnitude-ordered add/subtract with leading-one renormalisation.
    always_comb begin
        a_ge   = {fa.exp, fa.man} >= {fb.exp, fb.man};
        big    = a_ge ? fa : fb;
        sml    = a_ge ? fb : fa;
        sig_b  = (big.exp != '0) ? {1'b1, big.man, 3'b000} : '0;
        sig_s  = (sml.exp != '0) ? {1'b1, sml.man, 3'b000} : '0;
        diff   = big.exp - sml.exp;
        sig_sh = (diff >= EW'(SW)) ? '0 : (sig_s >> diff);
        sum    = (big.sign ^ sml.sign) ? ({1'b0, sig_b} - {1'b0, sig_sh})
                                       : ({1'b0, sig_b} + {1'b0, sig_sh});
        lz = '0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = (EW+1)'(SW - 1 - i);
        end
        norm    = sum[SW-1:0] << lz;
        exp_w   = '0;
        sum_res = '0;
        if (fp_is_special(fa.exp)) begin
            sum_res = fa;
        end else if (fp_is_special(fb.exp)) begin
            sum_res = fb;
        end else if (sum == '0) begin
            sum_res = '0;
        end else if (sum[SW]) begin
            exp_w        = {1'b0, big.exp} + (EW+1)'(1);
            sum_res.sign = big.sign;
            if (exp_w >= {1'b0, EMAX}) begin
                sum_res.exp = EMAX;
                sum_res.man = '0;
            end else begin
                sum_res.exp = exp_w[EW-1:0];
                sum_res.man = sum[SW-1 -: MW];
            end
        end else if ({1'b0, big.exp} <= lz) begin
            sum_res = '0;
        end else begin
            sum_res.sign = big.sign;
            sum_res.exp  = big.exp - lz[EW-1:0];
            sum_res.man  = norm[SW-2 -: MW];
        end
    end

    // Signed ordering for max/min, then final op select.
    always_comb begin
        if (fa.sign != fb.sign) a_gt = ~fa.sign;
        else if (fa.sign)       a_gt = {fa.exp, fa.man} < {fb.exp, fb.man};
        else                    a_gt = {fa.exp, fa.man} > {fb.exp, fb.man};
        case (fp_op_e'(op[1:0]))
            FP_ADD:  res = sum_res;
            FP_MAX:  res = a_gt ? fa : fb;
            FP_MIN:  res = a_gt ? fb : fa;
            default: res = '0;
        endcase
        result = res;
    end

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping mod N.
module rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant
);

    // Walk from the farthest candidate back to ptr so the nearest requester is the last writer.
    always_comb begin
        logic [PW-1:0] idx;
        grant = '0;
        idx   = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = PW'((int'(ptr) + k) % N);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_std_sched.sv
// Round-robin scheduler sharing one fp_std among NREQ lanes: operand reg, result reg, tagged response.
module fp_std_sched
    import fp_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = FP_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [15:0]           busy_cnt
);

    logic                 run_q;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [3:0]           s1_op_q, s1_op_d;
    logic [IDW-1:0]       s1_id_q, s1_id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic [15:0]          busy_q, busy_d;

    logic                 en;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       gnt_id;
    logic [WIDTH-1:0]     sel_a, sel_b, fp_res;
    logic [3:0]           sel_op;

    // Pipeline moves only when the result slot is empty or being drained; run_q keeps grants off in reset.
    assign en = ~rsp_valid_q | rsp_ready;

    rr_arb #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (en & run_q),
        .grant (grant)
    );

    assign req_ready = grant;

    // AND-OR operand mux keyed by grant so idle lanes' (possibly X) operands never leak in.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a  = sel_a  | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            sel_b  = sel_b  | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            sel_op = sel_op | (req_op[i*4 +: 4] & {4{grant[i]}});
            if (grant[i]) gnt_id = IDW'(i);
        end
    end

    fp_std #(.WIDTH(WIDTH)) u_fp (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (fp_res)
    );

    // Next-state for pointer, both pipeline stages and the saturating busy counter.
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        if (|grant) begin
            ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            s1_a_d  = sel_a;
            s1_b_d  = sel_b;
            s1_op_d = sel_op;
            s1_id_d = gnt_id;
        end
        if (en) begin
            s1_valid_d  = |grant;
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_data_d  = fp_res;
        end
        if (s1_valid_q && busy_q != 16'hFFFF) busy_d = busy_q + 16'd1;
    end

    // State registers; reset drops every in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= '0;
        end else begin
            run_q       <= 1'b1;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_fp_std_sched.sv
// Directed bench for fp_std_sched: FP results, arbitration order, backpressure, saturation, reset.
module tb_fp_std_sched;

    localparam int NREQ = 4;
    localparam int W    = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ*4-1:0] req_op;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic [15:0]       busy_cnt;

    int checks   = 0;
    int failures = 0;

    // lane i computes 1.0 + b_tab[i]; e_tab holds the hand-computed sums
    logic [W-1:0] b_tab [4] = '{24'h3F8000, 24'h3E8000, 24'h3F0000, 24'h400000};
    logic [W-1:0] e_tab [4] = '{24'h400000, 24'h3FA000, 24'h3FC000, 24'h404000};

    fp_std_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*4 +: 4] = op;
    endtask

    task automatic init_lanes();
        for (int i = 0; i < NREQ; i++) set_lane(i, 24'h3F8000, b_tab[i], 4'b0000);
    endtask

    // Check one cycle's outputs shortly after inputs were driven on the falling edge.
    task automatic at_cycle(input logic [3:0] rdy, input logic rv, input logic [1:0] id,
                            input logic [W-1:0] d);
        #1;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(id));
            chk("rsp_data", 32'(rsp_data), 32'(d));
        end
    endtask

    // Single op on an otherwise idle pipe: grant now, result two cycles later.
    task automatic one_op(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [W-1:0] expd);
        @(negedge clk);
        set_lane(lane, a, b, op);
        req_valid = 4'(1 << lane);
        at_cycle(4'(1 << lane), 1'b0, 2'd0, '0);
        @(negedge clk);
        req_valid = '0;
        at_cycle(4'b0000, 1'b0, 2'd0, '0);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'(lane), expd);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = 'x;
        req_b     = 'x;
        req_op    = 'x;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("xin_rsp_data", 32'(rsp_data), 32'd0);
        chk("xin_rsp_valid", 32'(rsp_valid), 32'd0);

        // 1.0 + 1.0
        one_op(0, 24'h3F8000, 24'h3F8000, 4'b0000, 24'h400000);
        // 2.0 - 1.0, max, min
        one_op(1, 24'h400000, 24'h3F8000, 4'b0100, 24'h3F8000);
        one_op(1, 24'h400000, 24'h3F8000, 4'b0001, 24'h400000);
        one_op(1, 24'h400000, 24'h3F8000, 4'b0010, 24'h3F8000);
        // 1.5 + 0.25, max(-2,1), 1 + (-1); ends on lane 3 so ptr wraps to 0
        one_op(3, 24'h3FC000, 24'h3E8000, 4'b0000, 24'h3FE000);
        one_op(3, 24'hC00000, 24'h3F8000, 4'b0001, 24'h3F8000);
        one_op(3, 24'h3F8000, 24'hBF8000, 4'b0000, 24'h000000);
        chk("busy_t2", 32'(busy_cnt), 32'd7);

        // all lanes streaming: grants 0,1,2,3,0, responses 0,1,2,3,0 two cycles behind
        init_lanes();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            at_cycle((k < 5) ? 4'(1 << (k % 4)) : 4'b0000, (k >= 2), 2'((k - 2) % 4),
                     e_tab[(k + 2) % 4]);
        end
        chk("busy_t3", 32'(busy_cnt), 32'd12);

        // backpressure: two accepted, then frozen, then drain in order
        @(negedge clk);
        init_lanes();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        at_cycle(4'b0010, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b1101;
        at_cycle(4'b0100, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b1001;
        at_cycle(4'b0000, 1'b1, 2'd1, e_tab[1]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd1, e_tab[1]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd1, e_tab[1]);
        @(negedge clk); rsp_ready = 1'b1;
        at_cycle(4'b1000, 1'b1, 2'd1, e_tab[1]);
        @(negedge clk); req_valid = 4'b0001;
        at_cycle(4'b0001, 1'b1, 2'd2, e_tab[2]);
        @(negedge clk); req_valid = 4'b0000;
        at_cycle(4'b0000, 1'b1, 2'd3, e_tab[3]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd0, e_tab[0]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b0, 2'd0, '0);
        chk("busy_t4", 32'(busy_cnt), 32'd19);

        // zero op
        one_op(2, 24'h3F8000, 24'h3F8000, 4'b0011, 24'h000000);
        chk("busy_t5", 32'(busy_cnt), 32'd20);

        // saturation: hold an op in S1 behind a stalled S2 long enough to pass 16'hFFFF
        @(negedge clk);
        init_lanes();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        at_cycle(4'b0001, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b0010;
        at_cycle(4'b0010, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b0000;
        at_cycle(4'b0000, 1'b1, 2'd0, e_tab[0]);
        repeat (65600) @(negedge clk);
        #1;
        chk("busy_sat", 32'(busy_cnt), 32'h0000FFFF);
        chk("stall_id", 32'(rsp_id), 32'd0);
        chk("stall_data", 32'(rsp_data), 32'(e_tab[0]));
        @(negedge clk); rsp_ready = 1'b1;
        at_cycle(4'b0000, 1'b1, 2'd0, e_tab[0]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd1, e_tab[1]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b0, 2'd0, '0);
        chk("busy_hold", 32'(busy_cnt), 32'h0000FFFF);

        // async reset with S1 and S2 both occupied (ptr is 2 here, lane 0 wins first)
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        at_cycle(4'b0001, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b0010;
        at_cycle(4'b0010, 1'b0, 2'd0, '0);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd0, e_tab[0]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_busy", 32'(busy_cnt), 32'd0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            at_cycle(4'b0000, 1'b0, 2'd0, '0);
        end
        @(negedge clk); req_valid = 4'b1001;
        at_cycle(4'b0001, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b1000;
        at_cycle(4'b1000, 1'b0, 2'd0, '0);
        @(negedge clk); req_valid = 4'b0000;
        at_cycle(4'b0000, 1'b1, 2'd0, e_tab[0]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b1, 2'd3, e_tab[3]);
        @(negedge clk);
        at_cycle(4'b0000, 1'b0, 2'd0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
